hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 103 ++++++++++
 tb/tb_hazard_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: register scoreboard interlock, taken-branch flush
// sequencing with a one-cycle PC redirect pulse, and a saturating stall counter.
module hazard_ctrl #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [4:0]        dec_rs1,
  input  logic [4:0]        dec_rs2,
  input  logic [4:0]        dec_rd,
  input  logic              dec_wr,
  input  logic              mem_busy,
  input  logic              br_valid,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  input  logic              cnt_clear,
  output logic              stall,
  output logic              flush,
  output logic              issue,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       stall_count
);

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  state_t      state, next_state;
  logic [31:0] pending, pending_next;
  logic [2:0]  flush_cnt;
  logic        hazard;
  logic        take_branch;

  // Hazard looks only at the registered scoreboard, so a same-cycle writeback
  // is not forwarded: the consumer stalls one cycle and issues on the next.
  always_comb begin
    hazard = 1'b0;
    if (dec_valid) begin
      if (dec_rs1 != 5'd0 && pending[dec_rs1]) hazard = 1'b1;
      if (dec_rs2 != 5'd0 && pending[dec_rs2]) hazard = 1'b1;
      if (dec_wr && dec_rd != 5'd0 && pending[dec_rd]) hazard = 1'b1;
    end
  end

  always_comb begin
    next_state  = state;
    stall       = 1'b0;
    issue       = 1'b0;
    take_branch = 1'b0;
    case (state)
      ST_IDLE: begin
        stall       = hazard | mem_busy;
        issue       = dec_valid & ~hazard & ~mem_busy;
        take_branch = br_valid & br_taken;
        if (take_branch) next_state = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_cnt == 3'd0) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Clear is applied before set so an issue and writeback to the same rd
  // leaves the bit set.
  always_comb begin
    pending_next = pending;
    if (wb_valid && wb_rd != 5'd0) pending_next[wb_rd] = 1'b0;
    if (issue && dec_wr && dec_rd != 5'd0) pending_next[dec_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      pending        <= '0;
      flush          <= 1'b0;
      flush_cnt      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      stall_count    <= '0;
    end else begin
      state          <= next_state;
      pending        <= pending_next;
      flush          <= (next_state == ST_FLUSH);
      redirect_valid <= take_branch;
      if (take_branch) begin
        redirect_pc <= br_target;
        flush_cnt   <= 3'(FLUSH_CYCLES - 1);
      end else if (state == ST_FLUSH && flush_cnt != 3'd0) begin
        flush_cnt <= flush_cnt - 3'd1;
      end
      if (cnt_clear)
        stall_count <= '0;
      else if (stall && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (default parameters) with
// hand-computed expectations.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_wr, mem_busy, br_valid, br_taken;
  logic [31:0] br_target;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        cnt_clear;
  logic        stall, flush, issue, redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] stall_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  hazard_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd), .dec_wr(dec_wr), .mem_busy(mem_busy),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .cnt_clear(cnt_clear),
    .stall(stall), .flush(flush), .issue(issue),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic decode(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic wr);
    dec_valid = v; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_wr = wr;
  endtask

  initial begin
    reset = 1'b1; decode(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    mem_busy = 1'b0; br_valid = 1'b0; br_taken = 1'b0; br_target = '0;
    wb_valid = 1'b0; wb_rd = '0; cnt_clear = 1'b0;
    step(); step();
    check("rst_stall", stall, 0);
    check("rst_issue", issue, 0);
    check("rst_flush", flush, 0);
    check("rst_rv", redirect_valid, 0);
    check("rst_rpc", redirect_pc, 0);
    check("rst_cnt", stall_count, 0);
    reset = 1'b0;

    // RAW on r5, released by writeback (no same-cycle forwarding)
    decode(1'b1, 5'd1, 5'd2, 5'd5, 1'b1); #1;
    check("raw_prod_issue", issue, 1);
    step();
    decode(1'b1, 5'd5, 5'd0, 5'd0, 1'b0); #1;
    check("raw_stall", stall, 1);
    check("raw_noissue", issue, 0);
    step();
    check("raw_cnt1", stall_count, 1);
    step();
    wb_valid = 1'b1; wb_rd = 5'd5; #1;
    check("raw_wb_samecyc_stall", stall, 1);
    step();
    wb_valid = 1'b0; #1;
    check("raw_release_issue", issue, 1);
    check("raw_cnt3", stall_count, 3);
    decode(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step();

    // r0 never becomes pending
    decode(1'b1, 5'd0, 5'd0, 5'd0, 1'b1); #1;
    check("r0_prod_issue", issue, 1);
    step();
    decode(1'b1, 5'd0, 5'd0, 5'd0, 1'b1); #1;
    check("r0_cons_stall", stall, 0);
    check("r0_cons_issue", issue, 1);
    decode(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step();

    // set beats clear on same register, same edge
    decode(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    wb_valid = 1'b1; wb_rd = 5'd7; #1;
    check("setclr_issue", issue, 1);
    step();
    wb_valid = 1'b0;
    decode(1'b1, 5'd7, 5'd0, 5'd0, 1'b0); #1;
    check("setclr_pending7", stall, 1);
    decode(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wb_valid = 1'b1; wb_rd = 5'd7;
    step();
    wb_valid = 1'b0;
    check("setclr_cnt", stall_count, 3);

    // taken branch: 2 flush cycles, one redirect pulse, second branch ignored
    br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h100;
    step();
    br_target = 32'h200;
    decode(1'b1, 5'd1, 5'd0, 5'd0, 1'b0); mem_busy = 1'b1; #1;
    check("br_rv1", redirect_valid, 1);
    check("br_rpc1", redirect_pc, 32'h100);
    check("br_flush1", flush, 1);
    check("br_issue_forced0", issue, 0);
    check("br_stall_forced0", stall, 0);
    step();
    br_valid = 1'b0; #1;
    check("br_flush2", flush, 1);
    check("br_rv2", redirect_valid, 0);
    step();
    check("br_flush_end", flush, 0);
    check("br_rpc_held", redirect_pc, 32'h100);
    check("br_idle_stall", stall, 1);
    mem_busy = 1'b0; decode(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("br_cnt", stall_count, 3);
    br_valid = 1'b1; br_taken = 1'b0; br_target = 32'h300;
    step();
    br_valid = 1'b0;
    check("nt_flush", flush, 0);
    check("nt_rv", redirect_valid, 0);
    check("nt_rpc", redirect_pc, 32'h100);

    // reset during first flush cycle
    decode(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
    br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h300;
    step();
    br_valid = 1'b0; decode(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("mid_flush", flush, 1);
    check("mid_rpc", redirect_pc, 32'h300);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_flush", flush, 0);
    check("abort_rv", redirect_valid, 0);
    check("abort_rpc", redirect_pc, 0);
    check("abort_cnt", stall_count, 0);
    decode(1'b1, 5'd9, 5'd0, 5'd0, 1'b0); #1;
    check("abort_pending_clear", issue, 1);
    decode(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step();

    // counter clear priority and saturation
    mem_busy = 1'b1;
    step(); step(); step();
    check("busy_cnt3", stall_count, 3);
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    check("clear_wins", stall_count, 0);
    repeat (70000) step();
    check("saturate", stall_count, 16'hFFFF);
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0; mem_busy = 1'b0;
    check("clear_after_sat", stall_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
